// File: rtl/acs_array_r2.sv
// Radix-2 add-compare-select array for a 2^(K-1)-state Viterbi trellis.
// Each accepted step updates all path metrics, emits one decision bit per
// state, reports the best state/metric and applies modulo normalization.
// Optional build macro: ACS_NORM_CNT_EN (saturating count of normalizations).
module acs_array_r2 #(
    parameter int K        = 3,
    parameter int BM_W     = 3,
    parameter int PM_W     = 8,
    parameter int INIT_PEN = 32,
    parameter int STEP_W   = 16,
    parameter int TB_DEPTH = 15,
    localparam int NUM_ST  = 1 << (K - 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_start,
    input  logic                       i_bm_valid,
    input  logic [2*NUM_ST*BM_W-1:0]   i_bm,
    output logic                       o_dec_valid,
    output logic [NUM_ST-1:0]          o_dec,
    output logic [K-2:0]               o_best_st,
    output logic [PM_W-1:0]            o_best_pm,
    output logic                       o_norm,
    output logic [STEP_W-1:0]          o_step,
    output logic                       o_tb_ready,
    output logic [7:0]                 o_norm_cnt
);

    logic [PM_W-1:0]   r_pm [NUM_ST];

    logic [PM_W:0]     w_sum0 [NUM_ST];
    logic [PM_W:0]     w_sum1 [NUM_ST];
    logic [PM_W-1:0]   w_cand0 [NUM_ST];
    logic [PM_W-1:0]   w_cand1 [NUM_ST];
    logic [PM_W-1:0]   w_new [NUM_ST];
    logic [PM_W-1:0]   w_pm_nxt [NUM_ST];
    logic [NUM_ST-1:0] w_dec;
    logic              w_all_hi;
    logic [K-2:0]      w_best_st;
    logic [PM_W-1:0]   w_best_pm;
    logic [STEP_W-1:0] w_step_nxt;

    // Add, saturate, compare-select per next state; predecessor p_j = {ns[K-3:0], j}.
    always_comb begin
        w_dec    = '0;
        w_all_hi = 1'b1;
        for (int ns = 0; ns < NUM_ST; ns++) begin
            w_sum0[ns]  = {1'b0, r_pm[(2*ns) % NUM_ST]}
                        + {{(PM_W+1-BM_W){1'b0}}, i_bm[(2*ns)*BM_W +: BM_W]};
            w_sum1[ns]  = {1'b0, r_pm[((2*ns) % NUM_ST) + 1]}
                        + {{(PM_W+1-BM_W){1'b0}}, i_bm[(2*ns+1)*BM_W +: BM_W]};
            w_cand0[ns] = w_sum0[ns][PM_W] ? '1 : w_sum0[ns][PM_W-1:0];
            w_cand1[ns] = w_sum1[ns][PM_W] ? '1 : w_sum1[ns][PM_W-1:0];
            w_dec[ns]   = (w_cand1[ns] < w_cand0[ns]);
            w_new[ns]   = w_dec[ns] ? w_cand1[ns] : w_cand0[ns];
            w_all_hi    = w_all_hi & w_new[ns][PM_W-1];
        end
    end

    // Modulo normalization: drop the MSB only when every metric has it set.
    always_comb begin
        for (int ns = 0; ns < NUM_ST; ns++) begin
            w_pm_nxt[ns] = w_all_hi ? {1'b0, w_new[ns][PM_W-2:0]} : w_new[ns];
        end
    end

    // Minimum search over normalized metrics; strict compare keeps the lowest index on ties.
    always_comb begin
        w_best_st = '0;
        w_best_pm = w_pm_nxt[0];
        for (int ns = 1; ns < NUM_ST; ns++) begin
            if (w_pm_nxt[ns] < w_best_pm) begin
                w_best_st = (K-1)'(ns);
                w_best_pm = w_pm_nxt[ns];
            end
        end
    end

    assign w_step_nxt = o_step + STEP_W'(1);

    // Metric registers, registered outputs and trellis-depth tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_ST; s++) begin
                r_pm[s] <= (s == 0) ? '0 : PM_W'(INIT_PEN);
            end
            o_dec_valid <= 1'b0;
            o_dec       <= '0;
            o_best_st   <= '0;
            o_best_pm   <= '0;
            o_norm      <= 1'b0;
            o_step      <= '0;
            o_tb_ready  <= 1'b0;
        end else if (i_start) begin
            for (int s = 0; s < NUM_ST; s++) begin
                r_pm[s] <= (s == 0) ? '0 : PM_W'(INIT_PEN);
            end
            o_dec_valid <= 1'b0;
            o_norm      <= 1'b0;
            o_step      <= '0;
            o_tb_ready  <= 1'b0;
        end else if (i_bm_valid) begin
            for (int s = 0; s < NUM_ST; s++) begin
                r_pm[s] <= w_pm_nxt[s];
            end
            o_dec_valid <= 1'b1;
            o_dec       <= w_dec;
            o_best_st   <= w_best_st;
            o_best_pm   <= w_best_pm;
            o_norm      <= w_all_hi;
            o_step      <= w_step_nxt;
            if (w_step_nxt == STEP_W'(TB_DEPTH)) begin
                o_tb_ready <= 1'b1;
            end
        end else begin
            o_dec_valid <= 1'b0;
            o_norm      <= 1'b0;
        end
    end

`ifdef ACS_NORM_CNT_EN
    logic [7:0] r_norm_cnt;

    // Saturating count of normalization events since start or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_norm_cnt <= '0;
        end else if (i_start) begin
            r_norm_cnt <= '0;
        end else if (i_bm_valid && w_all_hi && (r_norm_cnt != 8'hFF)) begin
            r_norm_cnt <= r_norm_cnt + 8'd1;
        end
    end

    assign o_norm_cnt = r_norm_cnt;
`else
    assign o_norm_cnt = 8'd0;
`endif

endmodule

// File: doc/acs_array_r2.md
Name: acs_array_r2

Overview:
- Parametrised radix-2 add-compare-select array for the Viterbi decoder. It is the successor of the fixed 4-state ACS and is generalised to 2^(K-1) states.
- Sits between the branch-metric unit and the survivor-memory/traceback unit.
- Each valid step it:
  - updates all path metrics,
  - emits one decision bit per state,
  - reports the best state and its metric,
  - performs modulo normalization.
- Also tracks the trellis depth so traceback knows when survivors are usable.

Parameters:
- K, 3, constraint length; NUM_ST = 2^(K-1) states.
- BM_W, 3, branch metric width.
- PM_W, 8, path metric width.
- INIT_PEN, 32, initial metric for all states except state 0.
- STEP_W, 16, step counter width.
- TB_DEPTH, 15, steps after start before o_tb_ready asserts.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_start  in  1  frame start: reload initial metrics, clear counters.
- i_bm_valid  in  1  i_bm holds one trellis step.
- i_bm  in  2*NUM_ST*BM_W  branch metrics; slice index 2*ns+j is the transition from predecessor p_j into next state ns.
- o_dec_valid  out  1  decisions/metrics valid, 1-cycle pulse.
- o_dec  out  NUM_ST  bit ns = selected predecessor j for state ns.
- o_best_st  out  K-1  state with the minimum new metric.
- o_best_pm  out  PM_W  that state's metric.
- o_norm  out  1  normalization applied this step.
- o_step  out  STEP_W  steps processed since start.
- o_tb_ready  out  1  sticky, set when o_step reaches TB_DEPTH.
- o_norm_cnt  out  8  see Optional Feature.

Behaviour:
- Trellis convention:
  - next state ns = {b, s[K-2:1]}.
  - predecessors of ns: p_j = {ns[K-3:0], j}, j ∈ {0,1}.
  - For K=3: ns0 ← 0,1; ns1 ← 2,3; ns2 ← 0,1; ns3 ← 2,3.
- Reset (rst=1, async):
  - pm[0]=0, pm[s≠0]=INIT_PEN.
  - All outputs 0; o_best_st=0; o_best_pm=0.
- Start: on i_start=1, next edge applies the same metric values as reset, clears o_step, o_tb_ready and the norm counter, and drives o_dec_valid=0.
  - i_start has priority over i_bm_valid in the same cycle; that bm sample is discarded.
- ACS step: on i_bm_valid=1 (and i_start=0), at the next edge:
  - cand_j = pm[p_j] + bm[2*ns+j], computed in PM_W+1 bits and saturated to 2^PM_W−1.
  - new[ns] = min(cand_0, cand_1); dec = 1 only if cand_1 < cand_0 (tie selects j=0).
  - pm, o_dec, o_best_st and o_best_pm all register on that edge; o_dec_valid=1 for one cycle.
  - Latency is 1 cycle; throughput is one step per cycle with no backpressure.
- Best state:
  - minimum over new metrics, after normalization.
  - tie goes to the lowest state index.
- Normalization:
  - if every new[ns] ≥ 2^(PM_W−1), store new[ns] − 2^(PM_W−1) (MSB cleared) and pulse o_norm=1 with o_dec_valid.
  - otherwise store unchanged with o_norm=0.
- o_step:
  - increments per accepted step and wraps at 2^STEP_W.
  - o_tb_ready sets on the edge where o_step becomes TB_DEPTH and stays set until start or reset, including across wrap.
- Idle (i_bm_valid=0): metrics and o_dec/o_best_* hold; o_dec_valid=0; o_norm=0.
- Reset mid-step: the in-flight step is lost and no o_dec_valid is produced.

Optional Feature:
- Macro: ACS_NORM_CNT_EN.
- Defined: o_norm_cnt counts o_norm pulses since start or reset and saturates at 255.
- Undefined: o_norm_cnt is tied to 0 and no counter logic is built.

Test Plan:
- Reset then start, one step with all bm=0 → o_dec=4'b0000, metrics {0,32,0,32}, o_best_st=0, o_best_pm=0, o_dec_valid pulse 1 cycle after i_bm_valid.
- After start, i_bm slices [2*ns+j] = {j0:5,j1:1 for ns0; 0,0 ns1; 1,5 ns2; 0,0 ns3} → cand ns0 = {5,33} → 5, dec 0; ns2 = {1,37} → 1, dec 0; o_best_st=2, o_best_pm=1.
- After start, 19 consecutive steps with all bm=7:
  - metrics {7,39,7,39}, then all 14, then +7 per step.
  - Step 18 gives 126 with o_norm=0; step 19 gives 5 with o_norm=1.
  - With ACS_NORM_CNT_EN, o_norm_cnt=1.
- i_start and i_bm_valid asserted together → no o_dec_valid, metrics equal the initial set, o_step=0.
- Run 15 steps → o_tb_ready rises on the 15th step's edge; i_start → o_tb_ready=0, o_step=0.
- Assert rst asynchronously mid-stream (between edges) → outputs zero immediately and metrics reload; first step after release behaves as in scenario 1.
